// File: rtl/tg_pkg.sv
// Shared constants for the traffic generator / checker pair.
package tg_pkg;

  // Bit positions inside the sticky err vector.
  localparam int unsigned ERR_LEN        = 0;
  localparam int unsigned ERR_KEEP_FMT   = 1;
  localparam int unsigned ERR_LAST_BYTES = 2;
  localparam int unsigned ERR_STABILITY  = 3;

  // Default stream width and the matching TKEEP width.
  localparam int unsigned DEF_WIDTH = 256;
  localparam int unsigned KEEP_W    = DEF_WIDTH / 8;

endpackage

// File: rtl/tg_bp_gen.sv
// TREADY backpressure pattern: M cycles ready, N cycles not ready, repeating.
module tg_bp_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] M,
  input  logic [15:0] N,
  output logic        ready
);

  logic [15:0] phase_q, phase_d;
  logic [15:0] m_q, n_q;
  logic [15:0] m_eff, n_eff;
  logic        ready_q, ready_d;

  // Next phase and ready. At phase 0 the live M/N are used and captured, so a
  // change only takes effect once the current period has wrapped.
  always_comb begin
    m_eff   = (phase_q == 16'd0) ? M : m_q;
    n_eff   = (phase_q == 16'd0) ? N : n_q;
    ready_d = 1'b1;
    phase_d = '0;
    if (m_eff != 16'd0 && n_eff != 16'd0) begin
      ready_d = (phase_q < m_eff);
      if ({1'b0, phase_q} == ({1'b0, m_eff} + {1'b0, n_eff} - 17'd1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 16'd1;
      end
    end
  end

  // Phase counter, captured period configuration and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      ready_q <= 1'b0;
    end else if (clear) begin
      phase_q <= '0;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ready_q <= ready_d;
      if (phase_q == 16'd0) begin
        m_q <= M;
        n_q <= N;
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/tg_checker.sv
// AXI Stream sink: applies backpressure, counts traffic, checks framing and
// stability against the expected packet shape.
module tg_checker
  import tg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [15:0]          num_flits,
  input  logic [7:0]           last_flit_bytes,
  input  logic [15:0]          M,
  input  logic [15:0]          N,
  input  logic [WIDTH-1:0]     TDATA,
  input  logic [WIDTH/8-1:0]   TKEEP,
  input  logic                 TVALID,
  output logic                 TREADY,
  input  logic                 TLAST,
  output logic [31:0]          pkt_count,
  output logic [31:0]          flit_count,
  output logic [47:0]          byte_count,
  output logic [3:0]           err,
  output logic [31:0]          first_err_pkt,
  output logic                 in_packet
);

  localparam int unsigned KW = WIDTH / 8;
  localparam logic [KW-1:0] KEEP_ONE = KW'(1);

  function automatic logic [7:0] popcnt(input logic [KW-1:0] k);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < KW; i++) c = c + 8'(k[i]);
    return c;
  endfunction

  // Nonzero and of the form 2^k-1 (contiguous ones from the LSB).
  function automatic logic keep_contig(input logic [KW-1:0] k);
    return (k != '0) && ((k & (k + KEEP_ONE)) == '0);
  endfunction

  logic [31:0]       pkt_q, pkt_d, flit_q, flit_d, first_q, first_d;
  logic [47:0]       byte_q, byte_d;
  logic [48:0]       bsum;
  logic [15:0]       cur_q, cur_d;
  logic [3:0]        err_q, err_d, err_new;
  logic              stall_q, stall_d;
  logic [WIDTH-1:0]  data_q;
  logic [KW-1:0]     keep_q;
  logic              last_q;
  logic              beat;
  logic [7:0]        pc, exp_last;

  tg_bp_gen u_bp (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .M     (M),
    .N     (N),
    .ready (TREADY)
  );

  // Error detection and next-state of counters for the current cycle.
  always_comb begin
    beat     = TVALID & TREADY & ~clear;
    pc       = popcnt(TKEEP);
    exp_last = (last_flit_bytes == 8'd0) ? 8'(KW) : last_flit_bytes;
    err_new  = '0;
    if (beat) begin
      if (!keep_contig(TKEEP) || (!TLAST && TKEEP != '1)) err_new[ERR_KEEP_FMT] = 1'b1;
      if (TLAST) begin
        if (num_flits != 16'd0 && ({1'b0, cur_q} + 17'd1) != {1'b0, num_flits})
          err_new[ERR_LEN] = 1'b1;
        if (pc != exp_last) err_new[ERR_LAST_BYTES] = 1'b1;
      end
    end
    if (!clear && stall_q &&
        (!TVALID || TDATA != data_q || TKEEP != keep_q || TLAST != last_q))
      err_new[ERR_STABILITY] = 1'b1;

    err_d   = err_q | err_new;
    first_d = (err_q == '0 && err_new != '0) ? pkt_q : first_q;

    pkt_d  = pkt_q;
    flit_d = flit_q;
    byte_d = byte_q;
    cur_d  = cur_q;
    bsum   = {1'b0, byte_q} + 49'(pc);
    if (beat) begin
      flit_d = (flit_q == '1) ? flit_q : flit_q + 32'd1;
      byte_d = bsum[48] ? '1 : bsum[47:0];
      if (TLAST) begin
        pkt_d = (pkt_q == '1) ? pkt_q : pkt_q + 32'd1;
        cur_d = '0;
      end else begin
        cur_d = (cur_q == '1) ? cur_q : cur_q + 16'd1;
      end
    end
    stall_d = TVALID & ~TREADY;
  end

  // Counter, error and stall-snapshot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q   <= '0;
      flit_q  <= '0;
      byte_q  <= '0;
      cur_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      stall_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (clear) begin
      pkt_q   <= '0;
      flit_q  <= '0;
      byte_q  <= '0;
      cur_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      stall_q <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      flit_q  <= flit_d;
      byte_q  <= byte_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      first_q <= first_d;
      stall_q <= stall_d;
      data_q  <= TDATA;
      keep_q  <= TKEEP;
      last_q  <= TLAST;
    end
  end

  assign pkt_count     = pkt_q;
  assign flit_count    = flit_q;
  assign byte_count    = byte_q;
  assign err           = err_q;
  assign first_err_pkt = first_q;
  assign in_packet     = (cur_q != 16'd0);

endmodule

// File: tb/tb_tg_checker.sv
// Randomized self-checking bench for tg_checker with a cycle-level model.
module tb_tg_checker;

  logic         clk = 1'b0;
  logic         rst, clear;
  logic [15:0]  num_flits, M, N;
  logic [7:0]   lfb;
  logic [255:0] TDATA;
  logic [31:0]  TKEEP;
  logic         TVALID, TLAST, TREADY;
  logic [31:0]  pkt_count, flit_count, first_err_pkt;
  logic [47:0]  byte_count;
  logic [3:0]   err;
  logic         in_packet;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tg_checker #(.WIDTH(256)) dut (
    .clk(clk), .rst(rst), .clear(clear), .num_flits(num_flits),
    .last_flit_bytes(lfb), .M(M), .N(N), .TDATA(TDATA), .TKEEP(TKEEP),
    .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST), .pkt_count(pkt_count),
    .flit_count(flit_count), .byte_count(byte_count), .err(err),
    .first_err_pkt(first_err_pkt), .in_packet(in_packet)
  );

  // Reference model state.
  bit           mr;
  int unsigned  mk;
  logic [31:0]  m_pkt, m_flit, m_first;
  logic [47:0]  m_byte;
  logic [3:0]   m_err;
  int           m_cur;
  bit           m_stall;
  logic [255:0] m_sd;
  logic [31:0]  m_sk;
  bit           m_sl;

  // Ready level after the e-th edge since reset/clear: first M of every M+N.
  function automatic bit pat_ready(int unsigned e);
    int unsigned m, n;
    m = M; n = N;
    if (m == 0 || n == 0) return 1'b1;
    return ((e - 1) % (m + n)) < m;
  endfunction

  function automatic bit contig(logic [31:0] k);
    int i = 0;
    while (i < 32 && k[i]) i++;
    if (i == 0) return 1'b0;
    for (int j = i; j < 32; j++) if (k[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mr = 0; mk = 0; m_pkt = 0; m_flit = 0; m_first = 0; m_byte = 0;
    m_err = 0; m_cur = 0; m_stall = 0; m_sd = '0; m_sk = '0; m_sl = 0;
  endtask

  task automatic model_edge();
    logic [3:0] ne;
    longint     t;
    int         want;
    ne = 0;
    if (clear) begin
      model_reset();
      return;
    end
    if (m_stall && (!TVALID || TDATA !== m_sd || TKEEP !== m_sk || TLAST !== m_sl)) ne[3] = 1;
    if (TVALID && mr) begin
      if (!contig(TKEEP) || (!TLAST && TKEEP != 32'hFFFF_FFFF)) ne[1] = 1;
      if (TLAST) begin
        if (num_flits != 0 && m_cur + 1 != int'(num_flits)) ne[0] = 1;
        want = (lfb == 0) ? 32 : int'(lfb);
        if ($countones(TKEEP) != want) ne[2] = 1;
      end
    end
    if (m_err == 0 && ne != 0) m_first = m_pkt;
    m_err = m_err | ne;
    if (TVALID && mr) begin
      if (m_flit != 32'hFFFF_FFFF) m_flit++;
      t = longint'(m_byte) + $countones(TKEEP);
      m_byte = (t > 64'h0000_FFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : t[47:0];
      if (TLAST) begin
        if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
        m_cur = 0;
      end else if (m_cur < 65535) m_cur++;
    end
    m_stall = TVALID && !mr;
    m_sd = TDATA; m_sk = TKEEP; m_sl = TLAST;
    mk++;
    mr = pat_ready(mk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [15:0] m, input logic [15:0] n);
    rst = 0; M = m; N = n; clear = 0; TVALID = 0; TLAST = 0;
    TKEEP = '1; TDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1;
  endtask

  // Present one beat and hold it until the model says it was accepted.
  task automatic send(input logic [31:0] keep, input bit last);
    bit acc;
    int n = 0;
    TVALID = 1; TKEEP = keep; TLAST = last; TDATA = {8{$urandom()}};
    do begin
      acc = mr;
      tick();
      n++;
    end while (!acc && n < 64);
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles", n);
    end
    TVALID = 0; TLAST = 0;
  endtask

  task automatic test_reset();
    do_reset(16'd0, 16'd0);
    tests++;
    if ({TREADY, pkt_count, flit_count, byte_count, err, first_err_pkt, in_packet} !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b pkt=%0d flit=%0d byte=%0d err=%b want all 0",
               TREADY, pkt_count, flit_count, byte_count, err);
    end
  endtask

  task automatic test_basic();
    do_reset(16'd0, 16'd0);
    num_flits = 3; lfb = 5;
    for (int p = 0; p < 4; p++) begin
      send(32'hFFFF_FFFF, 0);
      send(32'hFFFF_FFFF, 0);
      send(32'h0000_001F, 1);
      tests++;
      if (TREADY !== 1'b1) begin
        fails++;
        $display("FAIL basic_ready: got %0b want 1", TREADY);
      end
    end
    tests++;
    if (pkt_count !== 32'd4 || flit_count !== 32'd12 || byte_count !== 48'd276 || err !== 4'd0) begin
      fails++;
      $display("FAIL basic_counts: pkt=%0d flit=%0d byte=%0d err=%b want 4 12 276 0000",
               pkt_count, flit_count, byte_count, err);
    end
  endtask

  task automatic test_pattern();
    do_reset(16'd2, 16'd1);
    num_flits = 0; lfb = 0;
    TVALID = 1; TKEEP = '1; TLAST = 0; TDATA = 256'h1234;
    for (int i = 0; i < 30; i++) begin
      tick();
      tests++;
      if (TREADY !== ((i % 3) != 2)) begin
        fails++;
        $display("FAIL pattern_ready: cycle %0d got %0b want %0b", i, TREADY, (i % 3) != 2);
      end
    end
    TVALID = 0;
    tick();
    tests++;
    if (flit_count !== 32'd20 || err !== 4'd0 || in_packet !== 1'b1) begin
      fails++;
      $display("FAIL pattern_flits: flit=%0d err=%b inp=%0b want 20 0000 1",
               flit_count, err, in_packet);
    end
  endtask

  task automatic test_len();
    do_reset(16'd0, 16'd0);
    num_flits = 3; lfb = 0;
    send('1, 0); send('1, 0); send('1, 1);
    send('1, 0); send('1, 1);
    tests++;
    if (err !== 4'b0001 || first_err_pkt !== 32'd1) begin
      fails++;
      $display("FAIL len_short: err=%b first=%0d want 0001 1", err, first_err_pkt);
    end
    send('1, 0); send('1, 0); send('1, 1);
    tests++;
    if (err !== 4'b0001 || first_err_pkt !== 32'd1 || pkt_count !== 32'd3) begin
      fails++;
      $display("FAIL len_hold: err=%b first=%0d pkt=%0d want 0001 1 3", err, first_err_pkt, pkt_count);
    end
  endtask

  task automatic test_keep();
    do_reset(16'd0, 16'd0);
    num_flits = 0; lfb = 5;
    send('1, 0); send(32'h0000_0F0F, 1);
    tests++;
    if (err !== 4'b0110 || first_err_pkt !== 32'd0) begin
      fails++;
      $display("FAIL keep_last: err=%b first=%0d want 0110 0", err, first_err_pkt);
    end
    do_reset(16'd0, 16'd0);
    num_flits = 0; lfb = 0;
    send('1, 0); send(32'h7FFF_FFFF, 0); send('1, 1);
    tests++;
    if (err !== 4'b0010) begin
      fails++;
      $display("FAIL keep_mid: err=%b want 0010", err);
    end
  endtask

  task automatic test_stability();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset(16'd1, 16'd3);
      num_flits = 0; lfb = 0;
      TVALID = 1; TKEEP = '1; TLAST = 0; TDATA = 256'hA5;
      tick(); tick(); tick();
      if (mode == 0) TDATA = 256'h5A;
      else TVALID = 0;
      tick();
      TVALID = 0;
      tests++;
      if (err !== 4'b1000) begin
        fails++;
        $display("FAIL stability_%0s: err=%b want 1000", mode == 0 ? "data" : "valid", err);
      end
    end
  endtask

  task automatic test_random();
    bit stalled;
    for (int cfg = 0; cfg < 4; cfg++) begin
      do_reset(16'($urandom_range(3)), 16'($urandom_range(3)));
      num_flits = 16'($urandom_range(4));
      lfb = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(8, 1));
      for (int c = 0; c < 150; c++) begin
        if (!(stalled && $urandom_range(9) != 0)) begin
          TVALID = ($urandom_range(9) < 7);
          TLAST  = ($urandom_range(3) == 0);
          TDATA  = {8{$urandom()}};
          if ($urandom_range(9) == 0) TKEEP = $urandom();
          else if (TLAST && lfb != 0) TKEEP = 32'hFFFF_FFFF >> (32 - int'(lfb));
          else TKEEP = '1;
        end
        clear = ($urandom_range(49) == 0);
        stalled = TVALID && !mr && !clear;
        tick();
        clear = 0;
        tests++;
        if ({TREADY, pkt_count, flit_count, byte_count, err, first_err_pkt, in_packet} !==
            {mr, m_pkt, m_flit, m_byte, m_err, m_first, m_cur != 0}) begin
          fails++;
          $display("FAIL random cfg%0d cyc%0d: got rdy=%0b pkt=%0d flit=%0d byte=%0d err=%b first=%0d inp=%0b want rdy=%0b pkt=%0d flit=%0d byte=%0d err=%b first=%0d inp=%0b",
                   cfg, c, TREADY, pkt_count, flit_count, byte_count, err, first_err_pkt, in_packet,
                   mr, m_pkt, m_flit, m_byte, m_err, m_first, m_cur != 0);
        end
      end
    end
    TVALID = 0;
  endtask

  task automatic test_reset_mid();
    do_reset(16'd0, 16'd0);
    num_flits = 3; lfb = 0;
    send('1, 0); send('1, 0);
    tests++;
    if (in_packet !== 1'b1 || TREADY !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: inp=%0b rdy=%0b want 1 1", in_packet, TREADY);
    end
    #2 rst = 0;
    #1;
    tests++;
    if ({TREADY, pkt_count, flit_count, byte_count, err, first_err_pkt, in_packet} !== '0) begin
      fails++;
      $display("FAIL reset_mid: rdy=%0b flit=%0d byte=%0d inp=%0b want all 0",
               TREADY, flit_count, byte_count, in_packet);
    end
    @(negedge clk);
    model_reset();
    rst = 1;
  endtask

  task automatic test_clear();
    do_reset(16'd0, 16'd0);
    num_flits = 0; lfb = 0;
    send('1, 0); send(32'h0000_0F0F, 0); send('1, 1);
    tests++;
    if (err !== 4'b0010 || flit_count !== 32'd3 || pkt_count !== 32'd1) begin
      fails++;
      $display("FAIL clear_pre: err=%b flit=%0d pkt=%0d want 0010 3 1", err, flit_count, pkt_count);
    end
    clear = 1; TVALID = 1; TLAST = 1; TKEEP = '1;
    tick();
    clear = 0; TVALID = 0; TLAST = 0;
    tests++;
    if ({pkt_count, flit_count, byte_count, err, first_err_pkt, in_packet} !== '0) begin
      fails++;
      $display("FAIL clear: pkt=%0d flit=%0d byte=%0d err=%b first=%0d want all 0",
               pkt_count, flit_count, byte_count, err, first_err_pkt);
    end
    tick();
    tests++;
    if (flit_count !== 32'd0 || pkt_count !== 32'd0) begin
      fails++;
      $display("FAIL clear_beat: flit=%0d pkt=%0d want 0 0", flit_count, pkt_count);
    end
  endtask

  initial begin
    rst = 0; clear = 0; num_flits = 0; lfb = 0; M = 0; N = 0;
    TDATA = '0; TKEEP = '1; TVALID = 0; TLAST = 0;
    test_reset();
    test_basic();
    test_pattern();
    test_len();
    test_keep();
    test_stability();
    test_random();
    test_reset_mid();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
